// File: rtl/mem_responder_pkg.sv
//------------------------------------------------------------------------------
// mem_responder_pkg : reset levels, FSM encodings and wait-counter width
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_responder_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter preload for a given number of wait states (only used when > 0)
  function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
    return CNT_W'(wait_cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
//------------------------------------------------------------------------------
// mem_responder_if : core memory request bus; resp_err exists with MEM_RESP_ERR_EN
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             ready;
`ifdef MEM_RESP_ERR_EN
  logic             resp_err;

  modport master (output memread, memwrite, adr, writedata,
                  input  memdata, ready, resp_err);
  modport slave  (input  memread, memwrite, adr, writedata,
                  output memdata, ready, resp_err);
`else
  modport master (output memread, memwrite, adr, writedata,
                  input  memdata, ready);
  modport slave  (input  memread, memwrite, adr, writedata,
                  output memdata, ready);
`endif
endinterface

`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
//------------------------------------------------------------------------------
// mem_array : DEPTH x WIDTH storage, synchronous write, registered read port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_array #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              we,
  input  logic              re,
  input  logic [AWIDTH-1:0] idx,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  localparam logic [AWIDTH:0] C_DEPTH = (AWIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w_in_range;

  assign w_in_range = ({1'b0, idx} < C_DEPTH);

  // Storage is deliberately not reset so preloaded contents survive reset
  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      mem[idx] <= wdata;
    end
  end

  // A write response returns the data just written
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rdata <= '0;
    end else if (we) begin
      rdata <= wdata;
    end else if (re) begin
      rdata <= w_in_range ? mem[idx] : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// mem_responder : wait-state SRAM responder for the MIPS core memory port.
// Optional MEM_RESP_ERR_EN adds resp_err. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int AWIDTH      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_,
  mem_responder_if.slave  bus
);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wr;
  logic [AWIDTH-1:0] r_idx;
  logic [WIDTH-1:0]  r_wdata;

  logic              w_req;
  logic              w_idle;
  logic              w_enter_resp;
  logic              w_wr;
  logic [AWIDTH-1:0] w_idx_in;
  logic [AWIDTH-1:0] w_idx;
  logic [WIDTH-1:0]  w_wdata;
  logic              unused_adr;

  assign w_req    = bus.memread | bus.memwrite;
  assign w_idle   = (r_state == S_IDLE);
  assign w_idx_in = bus.adr[AWIDTH+1:2];

  // With zero wait states the array is accessed straight from the live request
  assign w_enter_resp = (w_idle && w_req && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == '0));
  assign w_wr    = w_idle ? bus.memwrite : r_wr;
  assign w_idx   = w_idle ? w_idx_in     : r_idx;
  assign w_wdata = w_idle ? bus.writedata : r_wdata;

  assign unused_adr = &{1'b0, bus.adr[WIDTH-1:AWIDTH+2], bus.adr[1:0]};

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_wr    <= bus.memwrite;
            r_idx   <= w_idx_in;
            r_wdata <= bus.writedata;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= wait_load(WAIT_CYCLES);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = (r_state == S_RESP);

`ifdef MEM_RESP_ERR_EN
  localparam logic [AWIDTH:0] C_DEPTH = (AWIDTH+1)'(DEPTH);

  logic r_err;
  logic w_err_in;

  assign w_err_in = ({1'b0, w_idx_in} >= C_DEPTH) ||
                    (bus.memread && bus.memwrite) ||
                    (bus.adr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_err <= 1'b0;
    end else if (w_idle && w_req) begin
      r_err <= w_err_in;
    end
  end

  assign bus.resp_err = bus.ready & r_err;
`endif

  mem_array #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) sram0 (
    .clk    (clk),
    .reset_ (reset_),
    .we     (w_enter_resp & w_wr),
    .re     (w_enter_resp & ~w_wr),
    .idx    (w_idx),
    .wdata  (w_wdata),
    .rdata  (bus.memdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//------------------------------------------------------------------------------
// tb_mem_responder : directed self-checking bench for mem_responder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  logic clk;
  logic reset_;

  int n_total;
  int n_pass;

  logic        err_seen;
  logic [31:0] rd;
  int          lat;

  mem_responder_if #(.WIDTH(32)) bus  ();
  mem_responder_if #(.WIDTH(32)) bus0 ();

  mem_responder #(.WIDTH(32), .DEPTH(256), .AWIDTH(8), .WAIT_CYCLES(2)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  mem_responder #(.WIDTH(32), .DEPTH(256), .AWIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // op = {memwrite, memread}; optionally alters adr/writedata during WAIT
  task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d, input bit chg, input logic [31:0] a2,
                        input logic [31:0] d2, output logic [31:0] rdata, output int lt);
    @(negedge clk);
    bus.memwrite  = op[1];
    bus.memread   = op[0];
    bus.adr       = a;
    bus.writedata = d;
    lt       = 0;
    rdata    = '0;
    err_seen = 1'b0;
    for (int k = 1; k <= 20 && lt == 0; k++) begin
      @(negedge clk);
      if (chg && k == 1) begin
        bus.adr       = a2;
        bus.writedata = d2;
      end
      if (bus.ready) begin
        lt    = k;
        rdata = bus.memdata;
`ifdef MEM_RESP_ERR_EN
        err_seen = bus.resp_err;
`endif
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
      end
    end
    if (lt == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      bus.memread  = 1'b0;
      bus.memwrite = 1'b0;
    end else begin
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, bus.ready}, 32'd0);
      check({tag, "_hold"}, bus.memdata, rdata);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset_  = 1'b0;
    bus.memread = 1'b0;  bus.memwrite = 1'b0;  bus.adr = '0;  bus.writedata = '0;
    bus0.memread = 1'b0; bus0.memwrite = 1'b0; bus0.adr = '0; bus0.writedata = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_memdata", bus.memdata, 32'd0);
    reset_ = 1'b1;

    // Preload through the write path
    do_req("pre4",  2'b10, 32'd16, 32'h0000_0044, 1'b0, 0, 0, rd, lat);
    do_req("pre6",  2'b10, 32'd24, 32'h0000_0066, 1'b0, 0, 0, rd, lat);
    do_req("pre10", 2'b10, 32'd40, 32'h0000_00AA, 1'b0, 0, 0, rd, lat);
    do_req("pre2",  2'b10, 32'd8,  32'h0000_0022, 1'b0, 0, 0, rd, lat);
    do_req("pre5",  2'b10, 32'd20, 32'h0000_0007, 1'b0, 0, 0, rd, lat);
    check("pre5_data", rd, 32'h0000_0007);

    // Read latency and data
    do_req("t1", 2'b01, 32'd20, 32'h0, 1'b0, 0, 0, rd, lat);
    check("t1_lat", 32'(lat), 32'd3);
    check("t1_data", rd, 32'h0000_0007);

    // Write then read back, neighbours untouched
    do_req("t2w", 2'b10, 32'd20, 32'hDEAD_BEEF, 1'b0, 0, 0, rd, lat);
    check("t2w_lat", 32'(lat), 32'd3);
    check("t2w_data", rd, 32'hDEAD_BEEF);
    do_req("t2r", 2'b01, 32'd20, 32'h0, 1'b0, 0, 0, rd, lat);
    check("t2r_data", rd, 32'hDEAD_BEEF);
    do_req("t2r4", 2'b01, 32'd16, 32'h0, 1'b0, 0, 0, rd, lat);
    check("t2_word4", rd, 32'h0000_0044);
    do_req("t2r6", 2'b01, 32'd24, 32'h0, 1'b0, 0, 0, rd, lat);
    check("t2_word6", rd, 32'h0000_0066);

    // Inputs changed during WAIT are ignored
    do_req("t4w", 2'b10, 32'd20, 32'h1234_5678, 1'b1, 32'd40, 32'hFFFF_0000, rd, lat);
    check("t4w_data", rd, 32'h1234_5678);
    do_req("t4r5", 2'b01, 32'd20, 32'h0, 1'b0, 0, 0, rd, lat);
    check("t4_word5", rd, 32'h1234_5678);
    do_req("t4r10", 2'b01, 32'd40, 32'h0, 1'b0, 0, 0, rd, lat);
    check("t4_word10", rd, 32'h0000_00AA);

    // Asynchronous reset in the middle of a write's WAIT
    @(negedge clk);
    bus.memwrite = 1'b1; bus.adr = 32'd8; bus.writedata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("t5_wait_ready", {31'd0, bus.ready}, 32'd0);
    #2 reset_ = 1'b0;
    #1;
    check("t5_rst_ready", {31'd0, bus.ready}, 32'd0);
    check("t5_rst_memdata", bus.memdata, 32'd0);
    bus.memwrite = 1'b0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    do_req("t5r", 2'b01, 32'd8, 32'h0, 1'b0, 0, 0, rd, lat);
    check("t5_lat", 32'(lat), 32'd3);
    check("t5_word2", rd, 32'h0000_0022);

    // Zero wait states, request held through ready
    @(negedge clk);
    bus0.memread = 1'b1; bus0.adr = 32'd0;
    @(negedge clk);
    check("t3_ready1", {31'd0, bus0.ready}, 32'd1);
    @(negedge clk);
    check("t3_gap", {31'd0, bus0.ready}, 32'd0);
    @(negedge clk);
    check("t3_ready2", {31'd0, bus0.ready}, 32'd1);
    bus0.memread = 1'b0;
    @(negedge clk);
    check("t3_idle", {31'd0, bus0.ready}, 32'd0);

`ifdef MEM_RESP_ERR_EN
    do_req("t6w", 2'b11, 32'd22, 32'h55AA_55AA, 1'b0, 0, 0, rd, lat);
    check("t6_err", {31'd0, err_seen}, 32'd1);
    check("t6w_data", rd, 32'h55AA_55AA);
    do_req("t6r", 2'b01, 32'd20, 32'h0, 1'b0, 0, 0, rd, lat);
    check("t6_clean_err", {31'd0, err_seen}, 32'd0);
    check("t6_word5", rd, 32'h55AA_55AA);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
